// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from a FIFO and sends them on a UART line.
// Each frame is start (0), 8 data bits LSB first, an optional even parity
// bit, and stop (1). Every bit lasts CLKS_PER_BIT clocks.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert the even-parity
// bit between data bit 7 and the stop bit (8E1). Left undefined, frames are 8N1.
//
// FIFO handshake: read is a one-cycle pop strobe. It is raised only from IDLE
// when empty=0 is sampled. The popped byte on DATA_IN is captured on the edge
// that ends the strobe (the FETCH cycle).
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] DATA_IN,
    output logic       read,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        read_q, read_d;
    logic        bit_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign bit_last = (cnt_q == LAST_CNT);

    // State and datapath registers; reset returns the line to idle-high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            read_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            read_q    <= read_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic: tx_d holds the line level for the coming bit cell
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        read_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!empty) begin
                    read_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Pop strobe is high this cycle, so DATA_IN holds the byte
                shift_d = DATA_IN;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d = ^DATA_IN;
`endif
                tx_d    = 1'b0;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_last) begin
                    cnt_d     = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign read       = read_q;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_last;
    assign state_dbg  = state_q;

endmodule
